boot_streamer: RTL and testbench

//  Host-side initiator for the UART boot protocol. On start, reads a 64-word

---
 rtl/boot_streamer.sv | 149 ++++++++++++++
 tb/tb_boot_streamer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_streamer.sv
// Host-side UART boot initiator: streams a local program image out as byte pairs,
// triggers the target readback, then compares every returned word against the image.
module boot_streamer #(
  parameter int WORDS          = 64,
  parameter int ADR_W          = 6,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             start,
  output logic [ADR_W-1:0] mem_adr,
  output logic             mem_rd_en,
  input  logic [15:0]      mem_dout,
  output logic [7:0]       tx_byte,
  output logic             tx_byte_en,
  input  logic             tx_afull,
  input  logic [7:0]       rx_byte,
  input  logic             rx_byte_en,
  output logic             scan_req,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [6:0]       err_count
);

  localparam int               TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(WORDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_READ, S_LATCH, S_SEND_HI, S_SEND_LO, S_SCAN,
    S_RX_HI, S_RX_LO, S_RD_CMP, S_CMP, S_DONE
  } state_t;

  state_t           r_state;
  logic [ADR_W-1:0] r_cnt;
  logic [15:0]      r_word;
  logic [7:0]       r_rx_hi;
  logic [15:0]      r_rx_word;
  logic [TO_W-1:0]  r_to_cnt;
  logic [6:0]       r_err;
  logic             r_pass;
  logic             r_timeout;

  logic       w_last;
  logic       w_sending;
  logic       w_mismatch;
  logic [6:0] w_err_next;

  assign w_last     = (r_cnt == LAST_ADR);
  assign w_sending  = (r_state == S_SEND_HI) || (r_state == S_SEND_LO);
  assign w_mismatch = (mem_dout != r_rx_word);
  assign w_err_next = r_err + {6'd0, w_mismatch};

  // NOTE: the strobes are decoded from the registered state rather than registered
  // a second time, so they react to tx_afull and ce in the very cycle they are issued.
  assign mem_adr    = r_cnt;
  assign mem_rd_en  = (r_state == S_READ) || (r_state == S_RD_CMP);
  assign tx_byte    = (r_state == S_SEND_HI) ? r_word[15:8] : r_word[7:0];
  assign tx_byte_en = ce && w_sending && !tx_afull;
  assign scan_req   = ce && (r_state == S_SCAN);
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done       = (r_state == S_DONE);
  assign pass       = r_pass;
  assign timeout    = r_timeout;
  assign err_count  = r_err;

  // NOTE: every register, data latches included, is reset so an abort leaves nothing stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_word    <= '0;
      r_rx_hi   <= '0;
      r_rx_word <= '0;
      r_to_cnt  <= '0;
      r_err     <= '0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err     <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_READ;
          end
        end
        S_READ:  r_state <= S_LATCH;
        S_LATCH: begin
          r_word  <= mem_dout;
          r_state <= S_SEND_HI;
        end
        S_SEND_HI: if (!tx_afull) r_state <= S_SEND_LO;
        S_SEND_LO: begin
          if (!tx_afull) begin
            if (w_last) begin
              r_state <= S_SCAN;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= S_READ;
            end
          end
        end
        S_SCAN: begin
          r_cnt    <= '0;
          r_to_cnt <= '0;
          r_state  <= S_RX_HI;
        end
        S_RX_HI, S_RX_LO: begin
          // A byte arriving on the expiry cycle still counts and restarts the wait.
          if (rx_byte_en) begin
            r_to_cnt <= '0;
            if (r_state == S_RX_HI) begin
              r_rx_hi <= rx_byte;
              r_state <= S_RX_LO;
            end else begin
              r_rx_word <= {r_rx_hi, rx_byte};
              r_state   <= S_RD_CMP;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_RD_CMP: r_state <= S_CMP;
        S_CMP: begin
          r_err <= w_err_next;
          if (w_last) begin
            r_pass  <= (w_err_next == 7'd0);
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_RX_HI;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_streamer.sv
// Randomised bench for boot_streamer: local memory model, loopback target and a
// scoreboard fed by a transfer-level reference model.
module tb_boot_streamer;

  localparam int WORDS = 64;
  localparam int ADR_W = 6;
  localparam int TO    = 1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ce = 1'b1;
  logic             start = 1'b0;
  logic [ADR_W-1:0] mem_adr;
  logic             mem_rd_en;
  logic [15:0]      mem_dout = 16'h0;
  logic [7:0]       tx_byte;
  logic             tx_byte_en;
  logic             tx_afull = 1'b0;
  logic [7:0]       rx_byte = 8'h0;
  logic             rx_byte_en = 1'b0;
  logic             scan_req, busy, done, pass, timeout;
  logic [6:0]       err_count;

  boot_streamer #(.WORDS(WORDS), .ADR_W(ADR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start),
    .mem_adr(mem_adr), .mem_rd_en(mem_rd_en), .mem_dout(mem_dout),
    .tx_byte(tx_byte), .tx_byte_en(tx_byte_en), .tx_afull(tx_afull),
    .rx_byte(rx_byte), .rx_byte_en(rx_byte_en), .scan_req(scan_req),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pass_e;
    logic       to_e;
    logic [6:0] err_e;
  } result_t;

  logic [15:0] img  [WORDS];
  logic [15:0] echo [WORDS];
  logic [7:0]  exp_tx [$];
  result_t     exp_res [$];
  result_t     last_res;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Local program memory: synchronous read, advances only on enabled cycles.
  always @(posedge clk) if (ce && mem_rd_en) mem_dout <= img[mem_adr];

  // Environment configuration, written by the main sequence only.
  bit ce_rand = 0, afull_rand = 0, afull_watch = 0;
  int rx_limit = 2 * WORDS;
  int stray_req = 0;

  // Monitor bookkeeping, written by the monitor only.
  int cyc = 0, tx_xfer = 0, scan_xfer = 0, scan_total = 0, done_total = 0;
  int last_rx_cyc = 0, done_cyc = 0;
  bit prev_afull = 0;

  // Environment state, written by the environment only.
  bit          rx_phase = 0, afull_fired = 0;
  int          rx_idx = 0, gap = 0, afull_left = 0, stray_sent = 0;
  int          env_scan_seen = 0, env_done_seen = 0;
  logic [15:0] ew;

  // Environment: clock enable, FIFO back-pressure and the loopback target.
  always @(posedge clk) begin
    #1;
    rx_byte_en = 1'b0;
    if (!rst_n) begin
      rx_phase      = 1'b0;
      afull_left    = 0;
      tx_afull      = 1'b0;
      ce            = 1'b1;
      env_scan_seen = scan_total;
      env_done_seen = done_total;
    end else begin
      if (done_total != env_done_seen) begin
        env_done_seen = done_total;
        rx_phase      = 1'b0;
      end
      if (scan_total != env_scan_seen) begin
        env_scan_seen = scan_total;
        rx_phase      = 1'b1;
        rx_idx        = 0;
        gap           = $urandom_range(2, 5);
      end
      ce = (ce_rand && !rx_phase) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (afull_watch && !afull_fired && tx_xfer == 21) begin
        afull_fired = 1'b1;
        afull_left  = 50;
      end
      if (afull_left > 0) begin
        tx_afull = 1'b1;
        afull_left--;
      end else begin
        tx_afull = afull_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      if (rx_phase) begin
        if (gap > 0) begin
          gap--;
        end else if (rx_idx < rx_limit) begin
          ew         = echo[rx_idx / 2];
          rx_byte    = rx_idx[0] ? ew[7:0] : ew[15:8];
          rx_byte_en = 1'b1;
          rx_idx++;
          gap = rx_idx[0] ? $urandom_range(0, 3) : $urandom_range(3, 8);
        end
      end else if (stray_sent < stray_req) begin
        rx_byte    = 8'($urandom);
        rx_byte_en = 1'b1;
        stray_sent++;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a byte or a result.
  always @(negedge clk) begin
    result_t r;
    cyc++;
    if (!rst_n) begin
      tx_xfer    = 0;
      scan_xfer  = 0;
      prev_afull = 1'b0;
    end else begin
      if (tx_byte_en) begin
        check("tx_en_while_afull", tx_afull, 0);
        if (exp_tx.size() == 0) fail("tx_unexpected_byte");
        else check("tx_byte", tx_byte, exp_tx.pop_front());
        tx_xfer++;
      end
      if (afull_watch && prev_afull && !tx_afull) begin
        check("tx_en_first_low_cycle", tx_byte_en, 1);
        check("tx_byte_after_afull", tx_byte, 8'h0A);
      end
      prev_afull = tx_afull;
      if (scan_req) begin
        scan_xfer++;
        scan_total++;
      end
      if (rx_byte_en) last_rx_cyc = cyc;
      if (done && ce) begin
        if (exp_res.size() == 0) begin
          fail("done_unexpected");
        end else begin
          r = exp_res.pop_front();
          check("err_count", err_count, r.err_e);
          check("pass", pass, r.pass_e);
          check("timeout", timeout, r.to_e);
        end
        check("busy_at_done", busy, 0);
        check("scan_pulses", scan_xfer, 1);
        check("tx_bytes_per_xfer", tx_xfer, 2 * WORDS);
        done_cyc   = cyc;
        tx_xfer    = 0;
        scan_xfer  = 0;
        done_total++;
      end
    end
  end

  // Reference model: one transfer in terms of the image, the echo and how many bytes return.
  task automatic expect_xfer(int lim);
    result_t     r;
    int          nw;
    logic [15:0] w;
    for (int i = 0; i < WORDS; i++) begin
      w = img[i];
      exp_tx.push_back(w[15:8]);
      exp_tx.push_back(w[7:0]);
    end
    nw = (lim / 2 > WORDS) ? WORDS : lim / 2;
    r.err_e = '0;
    for (int i = 0; i < nw; i++) if (echo[i] != img[i]) r.err_e++;
    r.to_e   = (lim < 2 * WORDS);
    r.pass_e = !r.to_e && (r.err_e == 0);
    exp_res.push_back(r);
    last_res = r;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2;
    start = 1'b1;
    do @(negedge clk); while (!ce);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_mem_adr"}, mem_adr, 0);
    check({tag, "_mem_rd_en"}, mem_rd_en, 0);
    check({tag, "_tx_byte"}, tx_byte, 0);
    check({tag, "_tx_byte_en"}, tx_byte_en, 0);
    check({tag, "_scan_req"}, scan_req, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  task automatic run_xfer(int lim, bit restart_while_busy);
    int d0;
    int k;
    rx_limit = lim;
    d0 = done_total;
    expect_xfer(lim);
    pulse_start();
    check("busy_after_start", busy, 1);
    if (restart_while_busy) begin
      for (k = 0; k < 5000 && tx_xfer < 50; k++) @(posedge clk);
      if (k == 5000) begin fail("wait_tx_50"); finish_test(); end
      pulse_start();
      for (k = 0; k < 5000 && rx_idx < 70; k++) @(posedge clk);
      if (k == 5000) begin fail("wait_rx_70"); finish_test(); end
      pulse_start();
    end
    for (k = 0; k < 20000 && done_total == d0; k++) @(posedge clk);
    if (done_total == d0) begin fail("done_never_seen"); finish_test(); end
    repeat (3) @(posedge clk);
  endtask

  task automatic load_image(bit randomise);
    for (int i = 0; i < WORDS; i++) begin
      img[i]  = randomise ? 16'($urandom) : 16'hA500 + 16'(i);
      echo[i] = img[i];
    end
  endtask

  initial begin
    int k;
    load_image(1'b0);
    repeat (3) @(posedge clk);
    #3;
    check_outputs_zero("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // 1: clean loopback, random ce and back-pressure
    ce_rand = 1; afull_rand = 1;
    run_xfer(2 * WORDS, 1'b0);
    ce_rand = 0; afull_rand = 0;

    // 2: two corrupted echo words, including the last one
    echo[5]  = echo[5] ^ 16'h0001;
    echo[63] = echo[63] ^ 16'h0001;
    run_xfer(2 * WORDS, 1'b0);
    load_image(1'b0);

    // 3: FIFO almost full for 50 cycles while the low byte of word 10 waits
    afull_watch = 1;
    run_xfer(2 * WORDS, 1'b0);
    afull_watch = 0;
    check("afull_episode_ran", afull_fired, 1);

    // 4: target stops after 40 bytes; word 25 lies beyond the cut-off
    echo[5]  = echo[5] ^ 16'h0100;
    echo[25] = echo[25] ^ 16'h0001;
    afull_rand = 1;
    run_xfer(40, 1'b0);
    afull_rand = 0;
    check("timeout_latency_in_range",
          (done_cyc - last_rx_cyc >= TO) && (done_cyc - last_rx_cyc <= TO + 5), 1);
    load_image(1'b1);

    // 5: reset while the low byte of word 30 is awaited, then a clean run
    rx_limit = 2 * WORDS;
    expect_xfer(2 * WORDS);
    pulse_start();
    for (k = 0; k < 5000 && rx_idx < 61; k++) begin @(posedge clk); #3; end
    if (rx_idx < 61) begin fail("wait_rx_word30"); finish_test(); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_tx.delete();
    exp_res.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_xfer(2 * WORDS, 1'b0);

    // 6: stray readback bytes while idle, then restarts while busy
    stray_req = 3;
    for (k = 0; k < 100 && stray_sent < stray_req; k++) @(posedge clk);
    if (stray_sent < stray_req) begin fail("wait_stray"); finish_test(); end
    repeat (4) @(posedge clk);
    #3;
    check("idle_busy", busy, 0);
    check("idle_pass_held", pass, last_res.pass_e);
    check("idle_err_held", err_count, last_res.err_e);
    check("idle_timeout_held", timeout, last_res.to_e);
    echo[7] = echo[7] ^ 16'h8000;
    run_xfer(2 * WORDS, 1'b1);
    check("scoreboard_drained", exp_tx.size() + exp_res.size(), 0);

    finish_test();
  end

endmodule
